data_mem_responder: RTL

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready request channel and a one-cycle response pulse. It replaces the single-cycle data memory so the pipeline can model real memory latency, stalling on `req_ready` low and consuming `rsp_valid`. It handles word, halfword and byte accesses with load sign-extension, store byte-lane merging and misalignment detection.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 49 ++++
 rtl/data_mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and the pipeline controller.
package mem_pkg;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;
  localparam logic [1:0] DT_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word stores and sign-extended sub-word loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  datatype,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  assign shamt   = {addr_lo, 3'b000};
  assign shifted = word >> shamt;

  always_comb begin
    wword     = word;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (datatype)
      DT_WORD: begin
        if (addr_lo != 2'b00) begin
          misalign = 1'b1;
        end else begin
          wword     = wdata;
          rdata_ext = word;
        end
      end
      DT_HALF: begin
        if (addr_lo[0]) begin
          misalign = 1'b1;
        end else begin
          wword     = (word & ~(32'h0000_FFFF << shamt)) | ({16'h0, wdata[15:0]} << shamt);
          rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
        end
      end
      DT_BYTE: begin
        wword     = (word & ~(32'h0000_00FF << shamt)) | ({24'h0, wdata[7:0]} << shamt);
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder: valid/ready request, one-cycle response pulse.
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down the configured latency
// RESP  | rsp_valid pulse, memory already committed
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_datatype,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_dt;
  logic [31:0] mem [DEPTH_WORDS];

  logic        fire, commit;
  logic        sel_write;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_dt;
  logic [AW-1:0] idx;
  logic [31:0] wword, rdata_ext;
  logic        misalign;
  logic        addr_unused;

  assign fire   = req_valid && req_ready;
  assign commit = (state != ST_RESP) && (state_next == ST_RESP);

  // With zero latency the commit edge is the acceptance edge, so use the live request.
  assign sel_write = (state == ST_IDLE) ? req_write    : lat_write;
  assign sel_addr  = (state == ST_IDLE) ? req_addr     : lat_addr;
  assign sel_wdata = (state == ST_IDLE) ? req_wdata    : lat_wdata;
  assign sel_dt    = (state == ST_IDLE) ? req_datatype : lat_dt;
  assign idx       = sel_addr[AW+1:2];
  assign addr_unused = ^sel_addr[31:AW+2];

  mem_lane_align u_align (
    .addr_lo   (sel_addr[1:0]),
    .datatype  (sel_dt),
    .wdata     (sel_wdata),
    .word      (mem[idx]),
    .wword     (wword),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (fire) state_next = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_dt    <= DT_WORD;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == ST_IDLE && fire) begin
        cnt       <= 4'(LATENCY);
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_dt    <= req_datatype;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_err   <= misalign;
        rsp_rdata <= (sel_write || misalign) ? 32'h0 : rdata_ext;
      end
    end
  end

  // Memory has no reset: contents survive Rst.
  always_ff @(posedge Clk) begin
    if (commit && !Rst && sel_write && !misalign) mem[idx] <= wword;
  end

endmodule
